// File: rtl/firebird7_in_gate1_tessent_mux_ctrl_pkg.sv
// Shared types and default sizing for the gate1 w3 IJTAG data-mux select sequencer.
// Per-state output encoding lives here, so the FSM and any future users decode states the same way.
package firebird7_in_gate1_tessent_mux_ctrl_pkg;

  localparam int DEF_WIDTH         = 3;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_ACK_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    FUNC       = 3'd0,
    HOLD_REQ   = 3'd1,
    SETTLE_IN  = 3'd2,
    IJTAG      = 3'd3,
    SETTLE_OUT = 3'd4,
    REL_WAIT   = 3'd5
  } mux_ctrl_state_t;

  typedef struct packed {
    logic select;
    logic hold_req;
    logic busy;
  } ctrl_out_t;

  // Output levels owned by each state; registered from the next state so they change on the transition edge.
  function automatic ctrl_out_t state_outputs(input mux_ctrl_state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      FUNC:       o = '{select: 1'b0, hold_req: 1'b0, busy: 1'b0};
      HOLD_REQ:   o = '{select: 1'b0, hold_req: 1'b1, busy: 1'b1};
      SETTLE_IN:  o = '{select: 1'b0, hold_req: 1'b1, busy: 1'b1};
      IJTAG:      o = '{select: 1'b1, hold_req: 1'b1, busy: 1'b0};
      SETTLE_OUT: o = '{select: 1'b0, hold_req: 1'b1, busy: 1'b1};
      REL_WAIT:   o = '{select: 1'b0, hold_req: 1'b0, busy: 1'b1};
      default:    o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_mux_ctrl_cnt.sv
// Loadable saturating down-counter; done is high while the count is zero, and a load takes effect on the next edge.
// Counts down on every cycle without a load, so the owner only has to pulse load on each state entry.
module firebird7_in_gate1_tessent_mux_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Sequences ijtag_select: hold handshake, settle, then switch; the reverse happens on release. Takeover latency is 2+SETTLE_CYCLES edges.
// The functional owner throttles the sequence through func_hold_ack; a missing ack edge after ACK_TIMEOUT cycles raises sticky timeout_err.
module firebird7_in_gate1_tessent_data_mux_ctrl
  import firebird7_in_gate1_tessent_mux_ctrl_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_takeover_req,
  input  logic             err_clear,
  input  logic             func_hold_ack,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic             func_hold_req,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] snapshot_data,
  output logic             ctrl_busy,
  output logic             timeout_err
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  mux_ctrl_state_t state;
  mux_ctrl_state_t state_nxt;
  ctrl_out_t       outs_q;
  logic            state_change;
  logic            timeout_set;
  logic            settle_done;
  logic            ack_done;

  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    case (state)
      FUNC: begin
        if (ijtag_takeover_req && !timeout_err) state_nxt = HOLD_REQ;
      end
      HOLD_REQ: begin
        if (func_hold_ack) begin
          state_nxt = SETTLE_IN;
        end else if (!ijtag_takeover_req) begin
          state_nxt = REL_WAIT;
        end else if (ack_done) begin
          state_nxt   = REL_WAIT;
          timeout_set = 1'b1;
        end
      end
      // A dropped request does not abort here: finish the switch, then IJTAG releases it.
      SETTLE_IN: begin
        if (settle_done) state_nxt = IJTAG;
      end
      IJTAG: begin
        if (!ijtag_takeover_req) state_nxt = SETTLE_OUT;
      end
      SETTLE_OUT: begin
        if (settle_done) state_nxt = REL_WAIT;
      end
      REL_WAIT: begin
        if (!func_hold_ack) begin
          state_nxt = FUNC;
        end else if (ack_done) begin
          state_nxt   = FUNC;
          timeout_set = 1'b1;
        end
      end
      default: state_nxt = FUNC;
    endcase
    state_change = (state_nxt != state);
  end

  // Both counters restart on every state entry; only the relevant states look at their done flag.
  firebird7_in_gate1_tessent_mux_ctrl_cnt #(.W(SET_W)) u_settle_cnt (
    .clk      (ijtag_tck),
    .reset    (ijtag_reset),
    .load     (state_change),
    .load_val (SET_W'(SETTLE_CYCLES - 1)),
    .done     (settle_done)
  );

  firebird7_in_gate1_tessent_mux_ctrl_cnt #(.W(ACK_W)) u_ack_cnt (
    .clk      (ijtag_tck),
    .reset    (ijtag_reset),
    .load     (state_change),
    .load_val (ACK_W'(ACK_TIMEOUT - 1)),
    .done     (ack_done)
  );

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state         <= FUNC;
      outs_q        <= '0;
      snapshot_data <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state  <= state_nxt;
      outs_q <= state_outputs(state_nxt);
      if (state == HOLD_REQ && func_hold_ack) snapshot_data <= functional_data_in;
      // A timeout on the same edge as err_clear must stay visible.
      if (timeout_set) begin
        timeout_err <= 1'b1;
      end else if (err_clear) begin
        timeout_err <= 1'b0;
      end
    end
  end

  assign ijtag_select  = outs_q.select;
  assign func_hold_req = outs_q.hold_req;
  assign ctrl_busy     = outs_q.busy;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Directed bench for the gate1 IJTAG data-mux select sequencer with default parameters (WIDTH 3, settle 4, ack timeout 255).
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  logic       ijtag_tck;
  logic       ijtag_reset;
  logic       ijtag_takeover_req;
  logic       err_clear;
  logic       func_hold_ack;
  logic [2:0] functional_data_in;
  logic       func_hold_req;
  logic       ijtag_select;
  logic [2:0] snapshot_data;
  logic       ctrl_busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  firebird7_in_gate1_tessent_data_mux_ctrl dut (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_takeover_req (ijtag_takeover_req),
    .err_clear          (err_clear),
    .func_hold_ack      (func_hold_ack),
    .functional_data_in (functional_data_in),
    .func_hold_req      (func_hold_req),
    .ijtag_select       (ijtag_select),
    .snapshot_data      (snapshot_data),
    .ctrl_busy          (ctrl_busy),
    .timeout_err        (timeout_err)
  );

  initial begin
    ijtag_tck = 1'b0;
    forever #5 ijtag_tck = ~ijtag_tck;
  end

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic go_to_ijtag();
    ijtag_takeover_req = 1'b1;
    tick();
    func_hold_ack = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    ijtag_reset = 1'b1;
    ijtag_takeover_req = 1'b0;
    err_clear = 1'b0;
    func_hold_ack = 1'b0;
    functional_data_in = 3'b000;
    repeat (2) tick();
    checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL reset_select: got %b want 0", ijtag_select); end
    checks++; if (func_hold_req !== 1'b0) begin errors++; $display("FAIL reset_hold_req: got %b want 0", func_hold_req); end
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ctrl_busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", timeout_err); end
    checks++; if (snapshot_data !== 3'b000) begin errors++; $display("FAIL reset_snapshot: got %b want 000", snapshot_data); end
    ijtag_reset = 1'b0;
    tick();
  endtask

  task automatic test_takeover();
    functional_data_in = 3'b101;
    ijtag_takeover_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) begin
        checks++; if (func_hold_req !== 1'b1) begin errors++; $display("FAIL takeover_hold_req: got %b want 1", func_hold_req); end
        checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL takeover_busy: got %b want 1", ctrl_busy); end
        func_hold_ack = 1'b1;
      end
      if (i == 2) functional_data_in = 3'b010;
      checks++;
      if (ijtag_select !== (i == 6)) begin
        errors++; $display("FAIL takeover_select_edge%0d: got %b want %b", i, ijtag_select, (i == 6));
      end
    end
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL ijtag_busy: got %b want 0", ctrl_busy); end
    checks++; if (func_hold_req !== 1'b1) begin errors++; $display("FAIL ijtag_hold_req: got %b want 1", func_hold_req); end
    checks++; if (snapshot_data !== 3'b101) begin errors++; $display("FAIL takeover_snapshot: got %b want 101", snapshot_data); end
    func_hold_ack = 1'b0;
    tick();
    checks++; if (ijtag_select !== 1'b1) begin errors++; $display("FAIL ack_drop_select: got %b want 1", ijtag_select); end
    checks++; if (func_hold_req !== 1'b1) begin errors++; $display("FAIL ack_drop_hold_req: got %b want 1", func_hold_req); end
    func_hold_ack = 1'b1;
    tick();
  endtask

  task automatic test_release();
    ijtag_takeover_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL release_select_edge%0d: got %b want 0", i, ijtag_select); end
      checks++;
      if (func_hold_req !== (i < 5)) begin
        errors++; $display("FAIL release_hold_req_edge%0d: got %b want %b", i, func_hold_req, (i < 5));
      end
    end
    tick();
    checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL rel_wait_busy: got %b want 1", ctrl_busy); end
    func_hold_ack = 1'b0;
    tick();
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL release_func_busy: got %b want 0", ctrl_busy); end
    checks++; if (func_hold_req !== 1'b0) begin errors++; $display("FAIL release_func_hold_req: got %b want 0", func_hold_req); end
  endtask

  task automatic test_reset_mid();
    go_to_ijtag();
    checks++; if (ijtag_select !== 1'b1) begin errors++; $display("FAIL midreset_pre_select: got %b want 1", ijtag_select); end
    ijtag_reset = 1'b1;
    tick();
    checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL midreset_select: got %b want 0", ijtag_select); end
    checks++; if (func_hold_req !== 1'b0) begin errors++; $display("FAIL midreset_hold_req: got %b want 0", func_hold_req); end
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", ctrl_busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b want 0", timeout_err); end
    ijtag_takeover_req = 1'b0;
    func_hold_ack = 1'b0;
    repeat (2) tick();
    ijtag_reset = 1'b0;
    tick();
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", ctrl_busy); end
  endtask

  task automatic test_timeout();
    int n;
    logic sel_seen;
    n = 0;
    sel_seen = 1'b0;
    ijtag_takeover_req = 1'b1;
    func_hold_ack = 1'b0;
    for (int i = 1; i <= 400 && n == 0; i++) begin
      tick();
      if (ijtag_select) sel_seen = 1'b1;
      if (timeout_err) n = i;
    end
    checks++; if (n !== 256) begin errors++; $display("FAIL timeout_edge: got %0d want 256", n); end
    checks++; if (func_hold_req !== 1'b0) begin errors++; $display("FAIL timeout_hold_req: got %b want 0", func_hold_req); end
    checks++; if (sel_seen !== 1'b0) begin errors++; $display("FAIL timeout_select_seen: got %b want 0", sel_seen); end
    tick();
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL timeout_func_busy: got %b want 0", ctrl_busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (func_hold_req !== 1'b0) begin errors++; $display("FAIL blocked_hold_req_%0d: got %b want 0", i, func_hold_req); end
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", timeout_err); end
    tick();
    checks++; if (func_hold_req !== 1'b1) begin errors++; $display("FAIL reenabled_hold_req: got %b want 1", func_hold_req); end
    ijtag_takeover_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    ijtag_takeover_req = 1'b1;
    func_hold_ack = 1'b0;
    tick();
    checks++; if (func_hold_req !== 1'b1) begin errors++; $display("FAIL abort_hold_req: got %b want 1", func_hold_req); end
    tick();
    ijtag_takeover_req = 1'b0;
    tick();
    checks++; if (func_hold_req !== 1'b0) begin errors++; $display("FAIL abort_rel_hold_req: got %b want 0", func_hold_req); end
    checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL abort_rel_busy: got %b want 1", ctrl_busy); end
    checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL abort_select: got %b want 0", ijtag_select); end
    tick();
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL abort_func_busy: got %b want 0", ctrl_busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", timeout_err); end
  endtask

  task automatic test_simultaneous();
    ijtag_takeover_req = 1'b1;
    func_hold_ack = 1'b0;
    repeat (255) tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL simul_pre_err: got %b want 0", timeout_err); end
    checks++; if (func_hold_req !== 1'b1) begin errors++; $display("FAIL simul_pre_hold_req: got %b want 1", func_hold_req); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL simul_err: got %b want 1", timeout_err); end
    checks++; if (func_hold_req !== 1'b0) begin errors++; $display("FAIL simul_hold_req: got %b want 0", func_hold_req); end
    ijtag_takeover_req = 1'b0;
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL simul_final_clear: got %b want 0", timeout_err); end
  endtask

  initial begin
    test_reset();
    test_takeover();
    test_release();
    test_reset_mid();
    test_timeout();
    test_abort();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
